// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: builds ALU operands, func and SUB/SRA control from
// one instruction per cycle and holds them in a valid/ready pipeline register.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   operand_A,
    output logic [XLEN-1:0]   operand_B,
    output logic [2:0]        func,
    output logic              control,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic              out_illegal,
    output logic [XLEN-1:0]   out_pc
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   shamt;

    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic [2:0]        dec_func;
    logic              dec_control;
    logic              dec_illegal;
    logic              dec_rd_we;
    logic              accept;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign shamt    = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_func    = funct3;
        dec_control = 1'b0;
        dec_illegal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_a       = rs1_data;
                dec_b       = rs2_data;
                dec_control = (funct3 == 3'b000 || funct3 == 3'b101) ? in_instr[30] : 1'b0;
            end
            OPC_IMM: begin
                dec_a = rs1_data;
                // Shifts take a 5-bit shamt; ADDI has no subtract form, so instr[30] is ignored there
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_b       = shamt;
                    dec_control = (funct3 == 3'b101) ? in_instr[30] : 1'b0;
                end else begin
                    dec_b = imm_i;
                end
            end
            OPC_LUI: begin
                dec_b    = imm_u;
                dec_func = 3'b000;
            end
            OPC_AUIPC: begin
                dec_a    = in_pc;
                dec_b    = imm_u;
                dec_func = 3'b000;
            end
            default: begin
                dec_func    = 3'b000;
                dec_illegal = 1'b1;
            end
        endcase
        dec_rd_we = !dec_illegal && (rd != '0);
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush only clears valid; the data registers keep their last contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            operand_A   <= '0;
            operand_B   <= '0;
            func        <= '0;
            control     <= 1'b0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
            out_pc      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            operand_A   <= dec_a;
            operand_B   <= dec_b;
            func        <= dec_func;
            control     <= dec_control;
            out_rd      <= rd;
            out_rd_we   <= dec_rd_we;
            out_illegal <= dec_illegal;
            out_pc      <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural decode/handshake model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] operand_A, operand_B;
    logic [2:0]  func;
    logic        control;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic [31:0] rf [32];

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_A(operand_A), .operand_B(operand_B),
        .func(func), .control(control),
        .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        c;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    // Reference decode written from the ISA field definitions
    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2);
        exp_t e;
        int unsigned f3;
        f3 = (ins >> 12) & 7;
        e = '0;
        e.f = 3'(f3);
        e.pc = pc;
        e.rd = 5'((ins >> 7) & 31);
        case (ins & 32'h7F)
            32'h33: begin
                e.a = r1; e.b = r2;
                e.c = (f3 == 0 || f3 == 5) && ((ins >> 30) & 1) == 1;
            end
            32'h13: begin
                e.a = r1;
                if (f3 == 1 || f3 == 5) begin
                    e.b = (ins >> 20) & 31;
                    e.c = (f3 == 5) && ((ins >> 30) & 1) == 1;
                end else begin
                    e.b = 32'($signed(ins) >>> 20);
                end
            end
            32'h37: begin e.b = ins & 32'hFFFFF000; e.f = 0; end
            32'h17: begin e.a = pc; e.b = ins & 32'hFFFFF000; e.f = 0; end
            default: begin e.ill = 1'b1; e.f = 0; end
        endcase
        e.we = !e.ill && (e.rd != 0);
        return e;
    endfunction

    logic m_valid;
    exp_t m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m <= ref_decode(in_instr, in_pc, rf[in_instr[19:15]], rf[in_instr[24:20]]);
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("m_rs1_addr", 32'(rs1_addr), 32'(in_instr[19:15]));
            chk("m_rs2_addr", 32'(rs2_addr), 32'(in_instr[24:20]));
            chk("m_operand_A", operand_A, m.a);
            chk("m_operand_B", operand_B, m.b);
            chk("m_func", 32'(func), 32'(m.f));
            chk("m_control", 32'(control), 32'(m.c));
            chk("m_out_rd", 32'(out_rd), 32'(m.rd));
            chk("m_out_rd_we", 32'(out_rd_we), 32'(m.we));
            chk("m_out_illegal", 32'(out_illegal), 32'(m.ill));
            chk("m_out_pc", out_pc, m.pc);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one instruction for a single accepting cycle with out_ready=1
    task automatic issue(logic [31:0] ins, logic [31:0] pc);
        step();
        in_instr = ins; in_pc = pc; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(string n, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                              logic c, logic [4:0] rd, logic we, logic ill);
        chk({n, "_valid"}, 32'(out_valid), 32'd1);
        chk({n, "_A"}, operand_A, a);
        chk({n, "_B"}, operand_B, b);
        chk({n, "_func"}, 32'(func), 32'(f));
        chk({n, "_control"}, 32'(control), 32'(c));
        chk({n, "_rd"}, 32'(out_rd), 32'(rd));
        chk({n, "_rd_we"}, 32'(out_rd_we), 32'(we));
        chk({n, "_illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        #10 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_A", operand_A, 32'd0);
        chk("rst_B", operand_B, 32'd0);
        chk("rst_misc", {func, control, out_rd, out_rd_we, out_illegal}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);

        rf[1] = 32'd5; rf[2] = 32'd7; rf[6] = 32'h80000000; rf[8] = 32'h11;
        issue(32'h002081B3, 32'h0);
        expect_out("add", 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        issue(32'h402081B3, 32'h4);
        expect_out("sub", 32'd5, 32'd7, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
        issue(32'h40435293, 32'h8);
        expect_out("srai", 32'h80000000, 32'd4, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0);
        issue(32'hFFF00093, 32'hC);
        expect_out("addi", 32'd0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0);
        issue(32'h123453B7, 32'h10);
        expect_out("lui", 32'd0, 32'h12345000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0);
        issue(32'h12345397, 32'h100);
        expect_out("auipc", 32'h100, 32'h12345000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0);
        chk("auipc_pc", out_pc, 32'h100);
        issue(32'h00000073, 32'h14);
        expect_out("ecall", 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        issue(32'h00208033, 32'h18);
        expect_out("add_x0", 32'd5, 32'd7, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);

        // Stall: hold ADD, present ADDI x4,x8,3 behind it
        step();
        in_instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_instr = 32'h00340213;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_A", operand_A, 32'd5);
            chk("stall_rd", 32'(out_rd), 32'd3);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        expect_out("unstall", 32'h11, 32'd3, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        chk("unstall_once", 32'(out_valid), 32'd0);

        // Flush a held entry while a new one arrives
        in_instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_instr = 32'h00340213; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_keep_A", operand_A, 32'd5);
        out_ready = 1'b1;
        step();
        chk("flush_lost", 32'(out_valid), 32'd0);

        // Asynchronous reset while stalled
        in_instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_A", operand_A, 32'd0);
        #2 rst = 1'b0;

        // Randomized traffic
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic [6:0] ops [5];
            ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17; ops[4] = 7'($urandom);
            step();
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins[6:0] = ops[$urandom_range(0, 4)];
            in_instr = ins;
            in_pc = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
        end
        step();
        in_valid = 1'b0; flush = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that sits directly upstream of the ALU. It accepts one 32-bit RV32I instruction per cycle from fetch and reads rs1/rs2 from the register file. It builds the ALU operands, the 3-bit func and the control bit (SUB/SRA select), then holds them in a pipeline register. Upstream and downstream use valid/ready handshakes, and a flush input discards the instruction in the register.

Parameters:
XLEN, 32, datapath width (only 32 is supported)
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard the held or arriving instruction
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
rs1_addr  out  5  combinational from in_instr[19:15]
rs2_addr  out  5  combinational from in_instr[24:20]
rs1_data  in  32  register file read data (asynchronous read)
rs2_data  in  32  register file read data
out_valid  out  1  operands valid to ALU/EX
out_ready  in  1  EX consumes this cycle
operand_A  out  32  ALU operand A
operand_B  out  32  ALU operand B
func  out  3  ALU function (instr funct3 encoding)
control  out  1  1 = SUB (func 000) or SRA (func 101)
out_rd  out  5  destination register
out_rd_we  out  1  writeback enable
out_illegal  out  1  unsupported opcode flag
out_pc  out  32  PC of the held instruction

Behaviour:
- Reset (asynchronous): out_valid=0, and operand_A, operand_B, func, control, out_rd, out_rd_we, out_illegal, out_pc are all 0.
- in_ready = !out_valid || out_ready. This path is purely combinational; there is no skid buffer.
- Accept: in_valid && in_ready && !flush. On the next edge the output register loads the decoded fields and out_valid=1. Latency is 1 cycle.
- Drain: out_valid && out_ready with no accept gives out_valid=0 on the next edge.
- Stall: out_valid && !out_ready holds all outputs bit-stable and keeps in_ready=0.
- flush has priority over everything else. On the next edge out_valid=0 and any arriving instruction is dropped. The data registers keep their old values.
- Decode by opcode in_instr[6:0]. In every case below, func = instr[14:12] unless stated otherwise, and out_illegal = 0.
  - OP (0110011):
    - A = rs1_data, B = rs2_data.
    - control = instr[30] when funct3 is 000 or 101; otherwise control = 0.
  - OP-IMM (0010011):
    - A = rs1_data.
    - funct3 001 or 101: B = {27'b0, instr[24:20]}; control = instr[30] only for funct3 101.
    - All other funct3: B = sign-extended instr[31:20]; control = 0. ADDI never subtracts.
  - LUI (0110111): A = 0, B = {instr[31:12], 12'b0}, func = 000, control = 0.
  - AUIPC (0010111): A = in_pc, B = {instr[31:12], 12'b0}, func = 000, control = 0.
  - Any other opcode: out_illegal = 1, A = B = 0, func = 0, control = 0, out_rd_we = 0. It still flows through the handshake as a normal entry.
- out_rd = instr[11:7].
- out_rd_we = 1 for legal instructions with rd != 0; otherwise 0.
- No hazard detection or forwarding: rs data is sampled at the accept edge. Interlocks belong to a separate block.
- Reset asserted mid-stall clears out_valid immediately, without waiting for the clock. After deassertion the first accept behaves as from reset.

Test Plan:
- After reset: all outputs 0 and in_ready=1. ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7, out_ready=1 → one cycle later: out_valid=1, operand_A=5, operand_B=7, func=000, control=0, out_rd=3, out_rd_we=1.
- SUB 0x402081B3 → control=1, func=000.
- SRAI x5,x6,4 (0x40435293), rs1_data=0x80000000 → func=101, control=1, operand_B=4.
- ADDI x1,x0,-1 (0xFFF00093) → operand_B=0xFFFFFFFF, control=0.
- LUI x7,0x12345 (0x123453B7) → operand_A=0, operand_B=0x12345000.
- AUIPC with in_pc=0x100 → operand_A=0x100.
- Stall then flush:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged.
  - Raise out_ready → the next instruction loads exactly once.
  - Assert flush together with in_valid → out_valid=0 on the next cycle and the instruction is lost.
- Illegal and rd=x0 cases:
  - ECALL 0x00000073 → out_illegal=1, out_rd_we=0, operands 0.
  - ADD with rd=x0 → out_rd_we=0.
- Reset mid-stream: assert rst between edges while out_valid=1 → out_valid drops before the next clock edge.
